// File: rtl/cpu_pkg.sv
// Shared CPU constants: peripheral base address, timer register
// word indices and TCON bit positions.
package cpu_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

    // Word index (addr[4:2]) of each timer register
    localparam logic [2:0] REG_TH      = 3'd0;
    localparam logic [2:0] REG_TL      = 3'd1;
    localparam logic [2:0] REG_TCON    = 3'd2;
    localparam logic [2:0] REG_IRQCNT  = 3'd3;
    localparam logic [2:0] REG_SYSTICK = 3'd4;
    localparam logic [2:0] REG_RSVD    = 3'd5;

    localparam int TCON_EN   = 0;
    localparam int TCON_IE   = 1;
    localparam int TCON_PEND = 2;

endpackage

// File: rtl/timer_irq_ctrl_prescaler.sv
// prescaler_ctr: divides clk by PRESCALE while enabled.
// Ports: clk_i, reset_i, en_i (count enable), clr_i (restart), tick_o.
module prescaler_ctr #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = $clog2(PRESCALE + 1);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    // A clear (TL write) suppresses the tick so the write wins.
    always_comb begin
        tick_o = en_i && !clr_i && (pc_q == LAST);
        pc_d   = pc_q + 1'b1;
        if (!en_i || clr_i || tick_o) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: memory-mapped interval timer with level interrupt.
// Ports: clk, reset (sync, high), addr/wdata/MemRd/MemWr bus in,
// rdata (combinational load data), IRQsig (registered interrupt).
module timer_irq_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = PERIPH_BASE,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] rdata,
    output logic        IRQsig
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic [31:0] irqcnt_q, irqcnt_d;
    logic [31:0] systick_q, systick_d;
    logic        irq_q, irq_d;

    logic [29:0] word_a;
    logic [2:0]  idx;
    logic        hit;
    logic        wr_th, wr_tl, wr_tcon;
    logic        tick, ovf, set_pend;

    // Byte offset bits are dropped; only whole words are decoded.
    assign word_a = 30'(addr >> 2);
    assign idx    = word_a[2:0];
    assign hit    = (word_a[29:3] == BASE_ADDR[31:5]) && (idx <= REG_RSVD);

    assign wr_th   = MemWr && hit && (idx == REG_TH);
    assign wr_tl   = MemWr && hit && (idx == REG_TL);
    assign wr_tcon = MemWr && hit && (idx == REG_TCON);

    prescaler_ctr #(
        .PRESCALE(PRESCALE)
    ) u_psc (
        .clk_i  (clk),
        .reset_i(reset),
        .en_i   (en_q),
        .clr_i  (wr_tl),
        .tick_o (tick)
    );

    assign ovf      = tick && (tl_q == 32'hFFFF_FFFF);
    assign set_pend = ovf && ie_q;

    always_comb begin
        rdata = '0;
        if (MemRd && hit) begin
            case (idx)
                REG_TH:      rdata = th_q;
                REG_TL:      rdata = tl_q;
                REG_TCON:    rdata = {29'd0, pend_q, ie_q, en_q};
                REG_IRQCNT:  rdata = irqcnt_q;
                REG_SYSTICK: rdata = systick_q;
                default:     rdata = '0;
            endcase
        end
    end

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        en_d      = en_q;
        ie_d      = ie_q;
        pend_d    = pend_q;
        irqcnt_d  = irqcnt_q;
        systick_d = systick_q + 32'd1;

        if (tick) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (wr_th) begin
            th_d = wdata;
        end
        if (wr_tl) begin
            tl_d = wdata;
        end
        if (wr_tcon) begin
            en_d = wdata[TCON_EN];
            ie_d = wdata[TCON_IE];
            if (wdata[TCON_PEND]) begin
                pend_d = 1'b0;
            end
        end
        // A new overflow beats a same-cycle clear so no event is lost.
        if (set_pend) begin
            pend_d   = 1'b1;
            irqcnt_d = irqcnt_q + 32'd1;
        end
        irq_d = pend_d && ie_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            pend_q    <= 1'b0;
            irqcnt_q  <= '0;
            systick_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            pend_q    <= pend_d;
            irqcnt_q  <= irqcnt_d;
            systick_q <= systick_d;
            irq_q     <= irq_d;
        end
    end

    assign IRQsig = irq_q;

endmodule
